// File: rtl/param_stack_pkg.sv
// param_stack_pkg: stack operation encoding shared by the stack and the instruction decoder.
package param_stack_pkg;
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;
  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction
endpackage

// File: rtl/param_stack_if.sv
// param_stack_if: push/pop strobes, data and status between decoder and stack.
interface param_stack_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH);
  logic             push;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [AW-1:0]    sp;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             udf;
  modport master (
    output push, pop, clr_err, din,
    input  dout, dout_vld, sp, count, empty, full, ovf, udf
  );
  modport slave (
    input  push, pop, clr_err, din,
    output dout, dout_vld, sp, count, empty, full, ovf, udf
  );
endinterface

// File: rtl/param_stack_ram.sv
// param_stack_ram: WIDTH x DEPTH storage, one write port, one registered read port.
module param_stack_ram #(
  parameter int  WIDTH = 4,
  parameter int  DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_d, rd_q;
  // read returns the pre-write word so a replace hands back the value it overwrites
  always_comb rd_d = re ? mem[ra] : rd_q;
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  assign rd = rd_q;
endmodule

// File: rtl/param_stack.sv
// param_stack: downward-growing stack with push/pop/replace, count status and sticky errors.
module param_stack
  import param_stack_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 256
) (
  input logic          clk,
  input logic          rst_n,
  param_stack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [AW-1:0] sp_d, sp_q, tos, wa;
  logic [AW:0]   count_d, count_q;
  logic          vld_d, vld_q, ovf_d, ovf_q, udf_d, udf_q;
  logic          we, re, empty, full;
  op_e           op;
  assign empty = count_q == '0;
  assign full  = count_q == FULL_CNT;
  assign tos   = sp_q + 1'b1;
  assign op    = decode_op(bus.push, bus.pop);
  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    vld_d   = 1'b0;
    ovf_d   = ovf_q & ~bus.clr_err;
    udf_d   = udf_q & ~bus.clr_err;
    we      = 1'b0;
    re      = 1'b0;
    wa      = sp_q;
    unique case (op)
      OP_NONE: ;
      OP_PUSH: begin
        ovf_d   = ovf_d | full;
        we      = ~full;
        sp_d    = full ? sp_q : sp_q - 1'b1;
        count_d = full ? count_q : count_q + 1'b1;
      end
      OP_POP: begin
        udf_d   = udf_d | empty;
        re      = ~empty;
        vld_d   = ~empty;
        sp_d    = empty ? sp_q : tos;
        count_d = empty ? count_q : count_q - 1'b1;
      end
      OP_REPL: begin
        // empty stack degrades to a plain push that also flags the missing pop
        udf_d   = udf_d | empty;
        we      = 1'b1;
        re      = ~empty;
        vld_d   = ~empty;
        wa      = empty ? sp_q : tos;
        sp_d    = empty ? sp_q - 1'b1 : sp_q;
        count_d = empty ? count_q + 1'b1 : count_q;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp_q    <= '1;
      count_q <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  param_stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .wa   (wa),
    .wd   (bus.din),
    .re   (re),
    .ra   (tos),
    .rd   (bus.dout)
  );
  assign bus.dout_vld = vld_q;
  assign bus.sp       = sp_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.ovf      = ovf_q;
  assign bus.udf      = udf_q;
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: scoreboard bench for a 4x4 stack plus an 8x256 async-reset burst.
module tb_param_stack;
  localparam int DA = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_b_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [3:0]  m[$];
  logic [31:0] exp_q[$];
  logic        e_ovf = 1'b0;
  logic        e_udf = 1'b0;
  always #5 clk = ~clk;
  param_stack_if #(.WIDTH(4), .DEPTH(DA)) a ();
  param_stack_if #(.WIDTH(8), .DEPTH(256)) b ();
  param_stack #(.WIDTH(4), .DEPTH(DA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  param_stack #(.WIDTH(8), .DEPTH(256)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(b.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (a.dout_vld) begin
      if (exp_q.size() == 0) chk("a_spurious_vld", 1, 0);
      else chk("a_dout", 32'(a.dout), exp_q.pop_front());
    end
    if (b.dout_vld) chk("b_spurious_vld", 1, 0);
  end
  task automatic op(input logic ps, input logic pp, input logic [3:0] d, input logic clr);
    logic so, su;
    so = 1'b0;
    su = 1'b0;
    case ({ps, pp})
      2'b10: if (m.size() < DA) m.push_back(d); else so = 1'b1;
      2'b01: if (m.size() > 0) exp_q.push_back(32'(m.pop_back())); else su = 1'b1;
      2'b11: if (m.size() > 0) begin
               exp_q.push_back(32'(m[$]));
               m[$] = d;
             end else begin
               m.push_back(d);
               su = 1'b1;
             end
      default: ;
    endcase
    e_ovf = (e_ovf & ~clr) | so;
    e_udf = (e_udf & ~clr) | su;
    a.push = ps;
    a.pop = pp;
    a.din = d;
    a.clr_err = clr;
    @(posedge clk);
    #1;
    a.push = 1'b0;
    a.pop = 1'b0;
    a.clr_err = 1'b0;
    chk("count", 32'(a.count), m.size());
    chk("sp", 32'(a.sp), (DA - 1 - m.size()) & (DA - 1));
    chk("empty", 32'(a.empty), 32'(m.size() == 0));
    chk("full", 32'(a.full), 32'(m.size() == DA));
    chk("ovf", 32'(a.ovf), 32'(e_ovf));
    chk("udf", 32'(a.udf), 32'(e_udf));
  endtask
  initial begin
    a.push = 1'b0; a.pop = 1'b0; a.clr_err = 1'b0; a.din = '0;
    b.push = 1'b0; b.pop = 1'b0; b.clr_err = 1'b0; b.din = '0;
    #12;
    rst_n = 1'b1;
    rst_b_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_sp", 32'(a.sp), 3);
    chk("rst_count", 32'(a.count), 0);
    chk("rst_empty", 32'(a.empty), 1);
    chk("rst_full", 32'(a.full), 0);
    chk("rst_ovf", 32'(a.ovf), 0);
    chk("rst_udf", 32'(a.udf), 0);
    chk("rst_dout", 32'(a.dout), 0);
    chk("rst_vld", 32'(a.dout_vld), 0);
    foreach (m[i]) chk("model_empty", 1, 0);
    for (int i = 0; i < 4; i++) op(1, 0, 4'hA + 4'(i), 0);
    for (int i = 0; i < 4; i++) op(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) op(1, 0, 4'hA + 4'(i), 0);
    op(1, 0, 4'h5, 0);
    op(0, 1, 0, 0);
    op(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) op(0, 1, 0, 0);
    op(0, 1, 0, 0);
    chk("udf_no_vld", 32'(a.dout_vld), 0);
    op(0, 1, 0, 1);
    op(0, 0, 0, 1);
    op(1, 0, 4'h1, 0);
    op(1, 0, 4'h2, 0);
    op(1, 1, 4'h7, 0);
    op(0, 1, 0, 0);
    op(0, 1, 0, 0);
    op(1, 1, 4'h9, 0);
    op(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) op(1, 0, 4'(3 * i + 2), 0);
    op(1, 1, 4'hE, 0);
    for (int i = 0; i < 4; i++) op(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom), 0);
    op(0, 0, 0, 0);
    op(0, 0, 0, 0);
    chk("sb_drain", exp_q.size(), 0);
    for (int i = 0; i < 100; i++) begin
      b.push = 1'b1;
      b.din = 8'(i);
      @(posedge clk);
      #1;
    end
    chk("b_count100", 32'(b.count), 100);
    chk("b_sp100", 32'(b.sp), 155);
    rst_b_n = 1'b0;
    #1;
    chk("b_rst_count", 32'(b.count), 0);
    chk("b_rst_sp", 32'(b.sp), 255);
    chk("b_rst_empty", 32'(b.empty), 1);
    chk("b_rst_dout", 32'(b.dout), 0);
    @(posedge clk);
    #1;
    chk("b_rst_hold", 32'(b.count), 0);
    b.push = 1'b0;
    rst_b_n = 1'b1;
    b.pop = 1'b1;
    @(posedge clk);
    #1;
    b.pop = 1'b0;
    chk("b_udf", 32'(b.udf), 1);
    chk("b_vld", 32'(b.dout_vld), 0);
    chk("b_count", 32'(b.count), 0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
